// File: rtl/disp_cmd_decoder.sv
// disp_cmd_decoder: decodes SPI host command bytes into frame-buffer pixel writes and swap requests.
// Latency: fb_we follows the third byte of a pixel by 1 cycle; swap_req and cmd_err follow their byte by 1 cycle.
// Backpressure: none; every rx_valid byte inside a frame is accepted, including back-to-back strobes.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   rx_frame              slave-select level (synchronised); a frame is one command plus payload
//   rx_valid, rx_data     one-cycle byte strobe and byte from the SPI receiver
//   fb_we, fb_addr,       frame-buffer write strobe, pixel address, pixel {b0,b1,b2}
//   fb_wdata
//   swap_req, swap_ack    level swap request, held until the scan engine acknowledges
//   busy                  high whenever the decoder is not idle
//   cmd_err               one-cycle pulse on an unknown command byte
// Optional build macro DISP_CMD_STATS_EN adds saturating counters pix_count (completed writes)
// and err_count (unknown commands plus dropped partial pixels). ADDR_W must be <= 16.
// Commands: 0xF0 WRITE_PIXELS (3-byte pixels), 0x10 SWAP, 0x20 SET_ADDR (lo, hi).

module disp_cmd_decoder #(
  parameter int ADDR_W     = 9,
  parameter int NUM_PIXELS = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_frame,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_wdata,
  output logic              swap_req,
  input  logic              swap_ack,
  output logic              busy,
  output logic              cmd_err
`ifdef DISP_CMD_STATS_EN
  ,
  output logic [15:0]       pix_count,
  output logic [7:0]        err_count
`endif
);

  localparam logic [7:0] CMD_WRITE_PIXELS = 8'hF0;
  localparam logic [7:0] CMD_SWAP         = 8'h10;
  localparam logic [7:0] CMD_SET_ADDR     = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PIX0,
    PIX1,
    PIX2,
    ALO,
    AHI,
    DISCARD
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              frame_q;
  logic              addr_set;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic [7:0]        b0;
  logic [7:0]        b1;
  logic [7:0]        addr_lo;

  logic              ptr_clr;
  logic              pix_wr;
  logic              b0_ld;
  logic              b1_ld;
  logic              lo_ld;
  logic              hi_ld;
  logic              swap_set;
  logic              err_set;
  logic              frame_end;
  logic              drop;

  assign busy    = (state != IDLE);
  assign ptr_inc = (ptr == ADDR_W'(NUM_PIXELS - 1)) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The byte of the current cycle is always decoded first; a frame end then
  // overrides the next state, so a byte coincident with the falling edge of
  // rx_frame still takes effect.
  always_comb begin
    state_nxt = state;
    ptr_clr   = 1'b0;
    pix_wr    = 1'b0;
    b0_ld     = 1'b0;
    b1_ld     = 1'b0;
    lo_ld     = 1'b0;
    hi_ld     = 1'b0;
    swap_set  = 1'b0;
    err_set   = 1'b0;
    frame_end = 1'b0;
    drop      = 1'b0;

    case (state)
      IDLE: begin
        if (rx_frame && !frame_q) state_nxt = CMD;
      end
      CMD: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_WRITE_PIXELS: begin
              state_nxt = PIX0;
              ptr_clr   = !addr_set;
            end
            CMD_SET_ADDR: state_nxt = ALO;
            CMD_SWAP: begin
              swap_set  = 1'b1;
              state_nxt = DISCARD;
            end
            default: begin
              err_set   = 1'b1;
              state_nxt = DISCARD;
            end
          endcase
        end
      end
      PIX0: begin
        if (rx_valid) begin
          b0_ld     = 1'b1;
          state_nxt = PIX1;
        end
      end
      PIX1: begin
        if (rx_valid) begin
          b1_ld     = 1'b1;
          state_nxt = PIX2;
        end
      end
      PIX2: begin
        if (rx_valid) begin
          pix_wr    = 1'b1;
          state_nxt = PIX0;
        end
      end
      ALO: begin
        if (rx_valid) begin
          lo_ld     = 1'b1;
          state_nxt = AHI;
        end
      end
      AHI: begin
        if (rx_valid) begin
          hi_ld     = 1'b1;
          state_nxt = CMD;
        end
      end
      DISCARD: state_nxt = DISCARD;
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && !rx_frame) begin
      frame_end = 1'b1;
      // Ending with one or two pixel bytes latched means a pixel is lost.
      drop      = (state_nxt == PIX1) || (state_nxt == PIX2);
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q  <= 1'b0;
      addr_set <= 1'b0;
      ptr      <= '0;
      b0       <= '0;
      b1       <= '0;
      addr_lo  <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
      swap_req <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      frame_q <= rx_frame;
      fb_we   <= pix_wr;
      cmd_err <= err_set;
      // A new SWAP beats a same-cycle ack; an extra SWAP while pending merges.
      swap_req <= (swap_req && !swap_ack) || swap_set;

      if (b0_ld) b0 <= rx_data;
      if (b1_ld) b1 <= rx_data;
      if (lo_ld) addr_lo <= rx_data;

      if (pix_wr) begin
        fb_addr  <= ptr;
        fb_wdata <= {b0, b1, rx_data};
        ptr      <= ptr_inc;
      end else if (ptr_clr) begin
        ptr <= '0;
      end else if (hi_ld) begin
        ptr <= ADDR_W'({rx_data, addr_lo});
      end

      if (frame_end) begin
        addr_set <= 1'b0;
      end else if (hi_ld) begin
        addr_set <= 1'b1;
      end
    end
  end

`ifdef DISP_CMD_STATS_EN
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign err_inc = {1'b0, err_set} + {1'b0, drop};
  assign err_sum = {1'b0, err_count} + {7'b0, err_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_count <= '0;
      err_count <= '0;
    end else begin
      if (fb_we && pix_count != 16'hFFFF) pix_count <= pix_count + 16'd1;
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
`endif

endmodule

// File: doc/disp_cmd_decoder.md
Name: disp_cmd_decoder

Overview:
Consumes the byte stream from the SPI slave receiver and turns host commands into frame-buffer writes and buffer-swap requests. Sits between the SPI byte receiver (upstream) and the dual frame buffer plus scan engine (downstream). A transaction is framed by the SPI slave-select. The first byte of a frame is the command; the remaining bytes are its payload.

Parameters:
ADDR_W, 9, frame-buffer pixel address width
NUM_PIXELS, 512, pixels per buffer; must be ≤ 2**ADDR_W; the write address wraps at this value

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_frame  in  1  high while SPI slave-select is asserted; already synchronised to clk
rx_valid  in  1  one-cycle strobe: rx_data holds a complete byte
rx_data  in  8  received byte
fb_we  out  1  frame-buffer write strobe, one cycle
fb_addr  out  ADDR_W  write pixel address
fb_wdata  out  24  pixel {b0,b1,b2} = {[23:16],[15:8],[7:0]}
swap_req  out  1  request back/front buffer swap; level signal, held until acknowledged
swap_ack  in  1  one-cycle acknowledge from scan engine at its frame boundary
busy  out  1  high whenever state ≠ IDLE
cmd_err  out  1  one-cycle pulse when an unknown command byte is received

Behaviour:
- Reset values: all outputs 0, write pointer 0, state IDLE.
- Reset is asynchronous. Reset mid-transaction aborts the transaction, with no partial write, and clears a pending swap.
- Command set:
  - 0xF0 WRITE_PIXELS: payload of 3-byte pixels.
  - 0x10 SWAP: no payload.
  - 0x20 SET_ADDR: payload of 2 bytes, address low byte then high byte, truncated to ADDR_W.
  - Any other byte: cmd_err pulse, then DISCARD.
- States:
  - IDLE → CMD on rising edge of rx_frame.
  - CMD: first rx_valid byte is decoded.
    - 0xF0 → PIX0. The write pointer is reset to 0 on entry, unless SET_ADDR ran earlier in the same frame.
    - 0x20 → ALO.
    - 0x10 → sets swap pending, then DISCARD.
    - Unknown → DISCARD.
  - PIX0 → PIX1 → PIX2 → PIX0, advancing one state per rx_valid byte and latching b0, b1, b2.
  - On the PIX2 byte: fb_we = 1 on the next cycle, with fb_addr = pointer and fb_wdata = {b0,b1,b2}. The pointer then increments, wrapping NUM_PIXELS-1 → 0. Latency is 1 cycle from the third rx_valid to fb_we.
  - ALO → AHI: loads the pointer and sets the addr-set flag.
  - AHI → CMD: a further command may follow in the same frame.
  - Payload bytes beyond the addressed range keep wrapping. There is no overflow error.
  - DISCARD: ignores bytes until the frame ends.
- Frame end: rx_frame low in any state returns to IDLE on the next clock.
  - A partial pixel (1 or 2 bytes) is dropped and causes no write.
  - The addr-set flag is cleared.
  - The write pointer is retained.
- Outside a frame, rx_valid is ignored.
- If rx_valid and the falling edge of rx_frame occur in the same cycle, the byte is accepted first, then the state returns to IDLE.
- Swap handshake:
  - swap_req rises the cycle after the SWAP byte and stays high until swap_ack is sampled high, then clears on the next clock.
  - A SWAP received while swap_req is already high merges into the pending request; no second request is generated.
  - If swap_ack and a new SWAP byte occur in the same cycle, swap_req stays high (new request).
- swap_ack while swap_req is low is ignored.
- Byte-level timing: consecutive rx_valid strobes may arrive on back-to-back cycles and must all be accepted.

Optional Feature:
DISP_CMD_STATS_EN
- Defined:
  - Adds output pix_count[15:0], a saturating count of completed fb_we writes since reset.
  - Adds output err_count[7:0], a saturating count of cmd_err pulses plus dropped partial pixels.
  - Both are cleared only by rst_n.
- Undefined: both ports and both counters are absent, and behaviour is otherwise identical.

Test Plan:
- Load: frame of 0xF0 followed by 32 pixels (0xFF, i, 0xFF), i = 0..31 → 32 fb_we pulses with fb_addr = i and fb_wdata = 0xFF{i}FF, each 1 cycle after the third byte; busy low after the frame.
- Swap: frame of 0x10 → swap_req high 1 cycle after the byte; it holds through 100 cycles with no ack; after one swap_ack pulse it is low on the next cycle; a second SWAP during pending → exactly one ack clears it.
- Partial pixel: frame of 0xF0, 0x11, 0x22, 0x33, 0x44, then end of frame → exactly one write of 0x112233 at address 0; next 0xF0 frame writes at address 0.
- Set address and wrap: frame of 0x20, 0xFE, 0x01, 0xF0 and 3 pixels (NUM_PIXELS = 512) → writes at 510, 511, 0.
- Unknown command: frame of 0x55 followed by 0xF0, 0x01, 0x02, 0x03 → cmd_err pulses once and no fb_we occurs.
- Reset mid-pixel: assert rst_n low after 2 payload bytes → all outputs 0 immediately and no write; with DISP_CMD_STATS_EN defined, pix_count = 0.
